// File: rtl/fsub_pkg.sv
// Shared definitions for the sequential single-precision subtractor.
// Field widths, state encoding and the alignment bundle.
package fsub_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int FP_W  = 1 + EXP_W + MAN_W;
   localparam int SIG_W = MAN_W + 1;

   localparam logic [EXP_W-1:0] BIAS = 8'd127;
   localparam logic [FP_W-1:0]  POS_ZERO = '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_SUB,
      S_NORM,
      S_DONE
   } state_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] mx;
      logic [SIG_W-1:0] my;
      logic             eff_sub;
   } align_t;

   function automatic logic [SIG_W-1:0] sig_of(
      input logic [FP_W-1:0] f
   );
      return {1'b1, f[MAN_W-1:0]};
   endfunction

endpackage

// File: rtl/fsub_align.sv
// Operand alignment: magnitude compare, swap so X >= Y,
// and right shift of Y's significand by the exponent gap.
module fsub_align
   import fsub_pkg::*;
(
   input  logic [FP_W-1:0] op_a,
   input  logic [FP_W-1:0] op_b,
   output align_t          al
);

   logic             a_ge;
   logic [FP_W-1:0]  x;
   logic [FP_W-1:0]  y;
   logic [EXP_W-1:0] diff;
   logic [SIG_W-1:0] my_full;

   always_comb begin
      // exponent sits above mantissa, so one compare orders both
      a_ge    = op_a[FP_W-2:0] >= op_b[FP_W-2:0];
      x       = a_ge ? op_a : op_b;
      y       = a_ge ? op_b : op_a;
      diff    = x[FP_W-2:MAN_W] - y[FP_W-2:MAN_W];
      my_full = sig_of(y);

      al.sign    = x[FP_W-1];
      al.exp     = x[FP_W-2:MAN_W];
      al.mx      = sig_of(x);
      al.my      = (diff >= 8'd24) ? '0 : (my_full >> diff);
      al.eff_sub = x[FP_W-1] ^ y[FP_W-1];
   end

endmodule

// File: rtl/fsub_seq.sv
// Multi-cycle single-precision a - b with truncation.
// IDLE -> ALIGN -> SUB -> NORM (repeats per left shift) -> DONE.
module fsub_seq
   import fsub_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [FP_W-1:0] result
);

   state_t state;
   state_t state_n;

   logic [FP_W-1:0]  op_a;
   logic [FP_W-1:0]  op_b;
   logic             sign_r;
   logic [EXP_W-1:0] exp_r;
   logic [SIG_W-1:0] mx_r;
   logic [SIG_W-1:0] my_r;
   logic             sub_r;
   logic [SIG_W:0]   sum_r;
   logic             zero_r;
   align_t           al;

   fsub_align u_align (
      .op_a (op_a),
      .op_b (op_b),
      .al   (al)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (start) state_n = S_ALIGN;
         S_ALIGN: state_n = S_SUB;
         S_SUB:   state_n = S_NORM;
         S_NORM: begin
            if (sum_r == '0 || sum_r[SIG_W] ||
                sum_r[SIG_W-1] || exp_r == 8'd1)
               state_n = S_DONE;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_a   <= '0;
         op_b   <= '0;
         sign_r <= 1'b0;
         exp_r  <= '0;
         mx_r   <= '0;
         my_r   <= '0;
         sub_r  <= 1'b0;
         sum_r  <= '0;
         zero_r <= 1'b0;
         done   <= 1'b0;
         result <= POS_ZERO;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  op_a <= a;
                  op_b <= {~b[FP_W-1], b[FP_W-2:0]};
               end
            end
            S_ALIGN: begin
               sign_r <= al.sign;
               exp_r  <= al.exp;
               mx_r   <= al.mx;
               my_r   <= al.my;
               sub_r  <= al.eff_sub;
               zero_r <= 1'b0;
            end
            S_SUB: begin
               // X >= Y after the swap, so the difference stays positive
               if (sub_r) sum_r <= {1'b0, mx_r} - {1'b0, my_r};
               else       sum_r <= {1'b0, mx_r} + {1'b0, my_r};
            end
            S_NORM: begin
               if (sum_r == '0) begin
                  zero_r <= 1'b1;
               end else if (sum_r[SIG_W]) begin
                  sum_r <= {1'b0, sum_r[SIG_W:1]};
                  exp_r <= exp_r + 8'd1;
               end else if (sum_r[SIG_W-1]) begin
                  zero_r <= 1'b0;
               end else if (exp_r == 8'd1) begin
                  zero_r <= 1'b1;
               end else begin
                  sum_r <= {sum_r[SIG_W-1:0], 1'b0};
                  exp_r <= exp_r - 8'd1;
               end
            end
            S_DONE: begin
               done   <= 1'b1;
               zero_r <= 1'b0;
               if (zero_r) result <= POS_ZERO;
               else result <= {sign_r, exp_r, sum_r[MAN_W-1:0]};
            end
            default: done <= 1'b0;
         endcase
      end
   end

endmodule

// File: doc/fsub_seq.md
FSUB_SEQ -- requirements
Module: fsub_seq

Interface
REQ-001 Parameters: none; the format is fixed to IEEE-754 single precision (1/8/23).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  32  minuend, single-precision.
REQ-006 b  input  32  subtrahend, single-precision.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when result is valid.
REQ-009 result  output  32  registered a - b; holds its value until the next done.

Function
REQ-010 The block computes a - b as a signed-magnitude add of a and b with sign_b inverted.
REQ-011 Both operands always carry the implicit leading 1; NaN, Inf, and denormal inputs are not handled.
REQ-012 Rounding is truncation; no guard, round, or sticky bits.
REQ-013 FSM states: IDLE, ALIGN, SUB, NORM, DONE.
REQ-014 IDLE: when start=1, capture a and b (with b's sign inverted) and go to ALIGN; otherwise stay in IDLE.
REQ-015 ALIGN, one cycle:
- swap the operands so X is the larger magnitude (compare exponent first, then mantissa);
- shift Y's 24-bit mantissa right by exp_X - exp_Y;
- a shift of 24 or more yields 0;
- result sign = sign_X; working exponent = exp_X.
REQ-016 SUB, one cycle: 25-bit sum = mX + mY if the signs are equal, else mX - mY. The difference is never negative.
REQ-017 NORM, evaluated once per cycle, in priority order:
- sum == 0: result = 0x00000000 (+0); go to DONE.
- bit24 set: shift right 1, exponent + 1; go to DONE.
- bit23 set: go to DONE.
- working exponent == 1: result = +0; go to DONE (underflow flush).
- otherwise: shift left 1, exponent - 1; stay in NORM.
REQ-018 Exponent overflow past 254 is not detected; the exponent wraps.
REQ-019 DONE: register result = {sign, exponent, mantissa[22:0]}; assert done for exactly this cycle; go to IDLE.
REQ-020 Latency: start sampled at edge 0 gives done high in the cycle after edge 4 when no left shift is needed, plus one cycle per left shift (maximum 23).
REQ-021 The block never reports -0; every zero result is +0.
REQ-022 start while busy=1 is ignored; operands are not re-captured.
REQ-023 A new start may be sampled in the cycle after done.
REQ-024 Changes on a and b after capture have no effect on the operation in flight.

Reset
REQ-025 While reset=0: state = IDLE, busy = 0, done = 0, result = 0x00000000, all working registers cleared.
REQ-026 A reset asserted mid-operation aborts the operation and produces no done pulse.
REQ-027 After reset deasserts, the block accepts start on the first clock edge.

Structure
REQ-028 The shared float package holds:
- field-width constants: EXP_W = 8, MAN_W = 23;
- the bias constant 127;
- the FSM state enumeration;
- the +0 constant.
REQ-029 One sub-module, fsub_align, holds the ALIGN logic: magnitude compare, swap, and right shift. SUB and NORM stay in fsub_seq.
REQ-030 No combinational path from a, b, or start to result or done.

Verification
REQ-031 3.0 - 1.0: a=0x40400000, b=0x3F800000 -> result=0x40000000, done 4 cycles after start.
REQ-032 1.0 - 0.75: a=0x3F800000, b=0x3F400000 -> result=0x3E800000 after 2 left shifts, done at cycle 6.
REQ-033 1.0 - (-1.0) -> 0x40000000 via the right-shift path. 1.0 - 3.0 -> 0xC0000000 via the swap path.
REQ-034 a = b = 0x41200000 -> result=0x00000000 (+0).
REQ-035 Pulse start during busy with different operands -> the first result is unchanged and only one done pulse occurs.
REQ-036 Assert reset in NORM -> busy=0, done=0, result=0 at once; no done pulse afterwards.
